// File: rtl/pmic_rail_sequencer.sv
// Rail sequencer: ordered power-up/down with pg qualification, LP/LB rail masks and a latched fault.
// Optional macro PMIC_INPUT_SYNC_EN adds 2-flop synchronisers on on_sw, lb_sw, lp_sw and pg.
module pmic_rail_sequencer #(
  parameter int                   NUM_RAILS   = 4,
  parameter int                   STEP_CYCLES = 8,
  parameter int                   PG_TIMEOUT  = 16,
  parameter logic [NUM_RAILS-1:0] LP_MASK     = NUM_RAILS'(4'b0011),
  parameter logic [NUM_RAILS-1:0] LB_MASK     = NUM_RAILS'(4'b0001)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on_sw,
  input  logic                 lb_sw,
  input  logic                 lp_sw,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic [2:0]           state,
  output logic                 fault,
  output logic                 busy
);

  localparam int CNT_MAX = (STEP_CYCLES > PG_TIMEOUT) ? STEP_CYCLES : PG_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_RAILS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_RAILS - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] PG_LIMIT  = CW'(PG_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_LP     = 3'd3,
    ST_LB     = 3'd4,
    ST_PWR_DN = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  // UP_SKIP marks a rail that was already on when PWR_UP was re-entered
  typedef enum logic [1:0] {
    UP_WAIT   = 2'd0,
    UP_SETTLE = 2'd1,
    UP_SKIP   = 2'd2
  } up_mode_e;

  state_e               state_q, state_d;
  up_mode_e             mode_q, mode_d;
  logic [NUM_RAILS-1:0] rail_en_q, rail_en_d;
  logic [NUM_RAILS-1:0] pend_q, pend_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 on_s, lb_s, lp_s;
  logic [NUM_RAILS-1:0] pg_s;

`ifdef PMIC_INPUT_SYNC_EN
  logic [NUM_RAILS+2:0] sync1_q, sync1_d, sync2_q, sync2_d;

  // Synchroniser next-state: raw inputs into stage 1, stage 1 into stage 2
  always_comb begin
    sync1_d = {on_sw, lb_sw, lp_sw, pg};
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign {on_s, lb_s, lp_s, pg_s} = sync2_q;
`else
  assign {on_s, lb_s, lp_s, pg_s} = {on_sw, lb_sw, lp_sw, pg};
`endif

  function automatic logic [NUM_RAILS-1:0] clr_top(input logic [NUM_RAILS-1:0] v);
    logic [NUM_RAILS-1:0] r;
    logic                 done;
    r    = v;
    done = 1'b0;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (!done && v[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end else begin
        done = done;
      end
    end
    return r;
  endfunction

  logic [IW-1:0]        idx_nxt, step_idx;
  logic [CW-1:0]        cnt_inc;
  logic [NUM_RAILS-1:0] dn_rails, live_bad, pend_bad, step_bit;
  logic                 pg_timeout, in_run, fault_req, dn_req, step_req;

  // Next-state and output computation; fault outranks power-down, which outranks mode changes
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rail_en_d = rail_en_q;
    pend_d    = pend_q;
    fault_d   = fault_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    step_req  = 1'b0;
    step_idx  = '0;
    step_bit  = '0;

    idx_nxt    = idx_q + IW'(1);
    cnt_inc    = cnt_q + CW'(1);
    dn_rails   = clr_top(rail_en_q);
    pend_bad   = pend_q & ~pg_s;
    live_bad   = rail_en_q & ~pend_q & ~pg_s;
    pg_timeout = (cnt_inc >= PG_LIMIT);
    in_run     = (state_q == ST_ACTIVE) || (state_q == ST_LP) || (state_q == ST_LB);

    if (state_q == ST_PWR_UP) begin
      fault_req = (mode_q == UP_WAIT) && !pg_s[idx_q] && pg_timeout;
    end else if (in_run) begin
      fault_req = (live_bad != '0) || ((pend_bad != '0) && pg_timeout);
    end else begin
      fault_req = 1'b0;
    end
    dn_req = !on_s && ((state_q == ST_PWR_UP) || in_run);

    if (fault_req) begin
      state_d   = ST_FAULT;
      mode_d    = UP_WAIT;
      rail_en_d = '0;
      pend_d    = '0;
      fault_d   = 1'b1;
      idx_d     = '0;
      cnt_d     = '0;
    end else if (dn_req) begin
      rail_en_d = dn_rails;
      pend_d    = '0;
      cnt_d     = '0;
      state_d   = (dn_rails == '0) ? ST_IDLE : ST_PWR_DN;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (on_s) begin
            step_req = 1'b1;
            pend_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PWR_UP: begin
          case (mode_q)
            UP_WAIT: begin
              if (pg_s[idx_q]) begin
                cnt_d = '0;
                if (idx_q == LAST_IDX) state_d = ST_ACTIVE;
                else                   mode_d  = UP_SETTLE;
              end else begin
                cnt_d = cnt_inc;
              end
            end
            UP_SETTLE: begin
              if (cnt_q == STEP_LAST) begin
                step_req = 1'b1;
                step_idx = idx_nxt;
              end else begin
                cnt_d = cnt_inc;
              end
            end
            UP_SKIP: begin
              if (idx_q == LAST_IDX) begin
                mode_d = UP_WAIT;
              end else begin
                step_req = 1'b1;
                step_idx = idx_nxt;
              end
            end
            default: mode_d = UP_WAIT;
          endcase
        end
        ST_ACTIVE: begin
          pend_d = '0;
          if (lb_s) begin
            state_d   = ST_LB;
            rail_en_d = rail_en_q & LB_MASK;
          end else if (lp_s) begin
            state_d   = ST_LP;
            rail_en_d = rail_en_q & LP_MASK;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_LP: begin
          pend_d = pend_bad;
          cnt_d  = (pend_bad != '0) ? cnt_inc : '0;
          if (lb_s) begin
            state_d   = ST_LB;
            rail_en_d = rail_en_q & LB_MASK;
            pend_d    = pend_bad & LB_MASK;
          end else if (!lp_s) begin
            step_req = 1'b1;
            pend_d   = '0;
          end else begin
            state_d = ST_LP;
          end
        end
        ST_LB: begin
          pend_d = pend_bad;
          cnt_d  = (pend_bad != '0) ? cnt_inc : '0;
          if (lb_s) begin
            state_d = ST_LB;
          end else if (lp_s) begin
            // rails newly switched on here are timed like a power-up rail
            state_d   = ST_LP;
            rail_en_d = LP_MASK;
            pend_d    = (pend_bad | ~rail_en_q) & LP_MASK;
            cnt_d     = '0;
          end else begin
            step_req = 1'b1;
            pend_d   = '0;
          end
        end
        ST_PWR_DN: begin
          if (cnt_q == STEP_LAST) begin
            rail_en_d = dn_rails;
            cnt_d     = '0;
            state_d   = (dn_rails == '0) ? ST_IDLE : ST_PWR_DN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_FAULT: begin
          if (!on_s) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
          end else begin
            state_d = ST_FAULT;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rail_en_d = '0;
          fault_d   = 1'b0;
        end
      endcase
    end

    // Move PWR_UP onto rail step_idx: enable it, or skip it if it is already on
    if (step_req) begin
      step_bit[step_idx] = 1'b1;
      state_d            = ST_PWR_UP;
      idx_d              = step_idx;
      cnt_d              = '0;
      mode_d             = rail_en_q[step_idx] ? UP_SKIP : UP_WAIT;
    end else begin
      step_bit = '0;
    end
    rail_en_d = rail_en_d | step_bit;

    busy_d = (state_d == ST_PWR_UP) || (state_d == ST_PWR_DN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= UP_WAIT;
      rail_en_q <= '0;
      pend_q    <= '0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rail_en_q <= rail_en_d;
      pend_q    <= pend_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rail_en = rail_en_q;
  assign state   = state_q;
  assign fault   = fault_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pmic_rail_sequencer.sv
// Scoreboard bench for pmic_rail_sequencer: directed stimulus queues timed expected output events,
// a negedge monitor pops and compares one entry each time state/rail_en/fault/busy change.
module tb_pmic_rail_sequencer;

`ifdef PMIC_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int P = 6 + SL;

  localparam logic [2:0] S_IDLE = 3'd0, S_UP = 3'd1, S_ACT = 3'd2, S_LP = 3'd3;
  localparam logic [2:0] S_LB = 3'd4, S_DN = 3'd5, S_FLT = 3'd6;

  logic       clk, reset, on_sw, lb_sw, lp_sw;
  logic [3:0] pg, pg_dly, pg_kill, rail_en;
  logic [2:0] state;
  logic       fault, busy;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [3:0] re;
    logic       flt;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] prev = 9'd0;

  pmic_rail_sequencer #(
    .NUM_RAILS(4), .STEP_CYCLES(4), .PG_TIMEOUT(8),
    .LP_MASK(4'b0011), .LB_MASK(4'b0001)
  ) dut (
    .clk(clk), .reset(reset), .on_sw(on_sw), .lb_sw(lb_sw), .lp_sw(lp_sw),
    .pg(pg), .rail_en(rail_en), .state(state), .fault(fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // board model: each rail reports power-good one cycle after its enable, unless forced low
  initial pg_dly = 4'b0000;
  always @(posedge clk) pg_dly <= rail_en;
  assign pg = pg_dly & ~pg_kill;

  // monitor: every output change must match the next expected event, including its cycle
  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t       e;
    logic       ebusy;
    cur = {state, rail_en, fault, busy};
    if (cur !== prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got st=%0d re=%b flt=%b busy=%b, required no change",
                 cyc, state, rail_en, fault, busy);
      end else begin
        e = sb_q.pop_front();
        ebusy = (e.st == S_UP) || (e.st == S_DN);
        if (e.cyc != cyc || state !== e.st || rail_en !== e.re || fault !== e.flt || busy !== ebusy) begin
          failures++;
          $display("FAIL event got cyc=%0d st=%0d re=%b flt=%b busy=%b, required cyc=%0d st=%0d re=%b flt=%b busy=%b",
                   cyc, state, rail_en, fault, busy, e.cyc, e.st, e.re, e.flt, ebusy);
        end
      end
      prev = cur;
    end
  end

  task automatic push_exp(input int at, input logic [2:0] st, input logic [3:0] re, input logic flt);
    exp_t e;
    e.cyc = at; e.st = st; e.re = re; e.flt = flt;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int at);
    while (cyc < at) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic power_up_full();
    int e0;
    on_sw = 1'b1;
    e0 = cyc + 1 + SL;
    push_exp(e0, S_UP, 4'b0001, 1'b0);
    push_exp(e0 + P, S_UP, 4'b0011, 1'b0);
    push_exp(e0 + 2 * P, S_UP, 4'b0111, 1'b0);
    push_exp(e0 + 3 * P, S_UP, 4'b1111, 1'b0);
    push_exp(e0 + 3 * P + 2 + SL, S_ACT, 4'b1111, 1'b0);
    wait_until(e0 + 3 * P + 2 + SL + 3);
  endtask

  task automatic power_down_full();
    int d;
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_DN, 4'b0111, 1'b0);
    push_exp(d + 4, S_DN, 4'b0011, 1'b0);
    push_exp(d + 8, S_DN, 4'b0001, 1'b0);
    push_exp(d + 12, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 15);
  endtask

  task automatic set_mode(input logic lb, input logic lp, input logic [2:0] st, input logic [3:0] re);
    int m;
    lb_sw = lb;
    lp_sw = lp;
    m = cyc + 1 + SL;
    push_exp(m, st, re, 1'b0);
    wait_until(m + 6);
  endtask

  initial begin
    int e0, d, r, c;
    reset = 1'b1; on_sw = 1'b0; lb_sw = 1'b0; lp_sw = 1'b0; pg_kill = 4'b0000;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, rail_en, fault, busy} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state got st=%0d re=%b flt=%b busy=%b, required all 0", state, rail_en, fault, busy);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // power up then power down, full sequence
    power_up_full();
    power_down_full();

    // mode changes and re-entry through PWR_UP
    power_up_full();
    set_mode(1'b0, 1'b1, S_LP, 4'b0011);
    set_mode(1'b1, 1'b1, S_LB, 4'b0001);
    set_mode(1'b0, 1'b1, S_LP, 4'b0011);
    lp_sw = 1'b0;
    r = cyc + 1 + SL;
    push_exp(r, S_UP, 4'b0011, 1'b0);
    push_exp(r + 2, S_UP, 4'b0111, 1'b0);
    push_exp(r + 8 + SL, S_UP, 4'b1111, 1'b0);
    push_exp(r + 10 + 2 * SL, S_ACT, 4'b1111, 1'b0);
    wait_until(r + 10 + 2 * SL + 3);
    power_down_full();

    // pg timeout on rail 2
    pg_kill = 4'b0100;
    on_sw = 1'b1;
    e0 = cyc + 1 + SL;
    push_exp(e0, S_UP, 4'b0001, 1'b0);
    push_exp(e0 + P, S_UP, 4'b0011, 1'b0);
    push_exp(e0 + 2 * P, S_UP, 4'b0111, 1'b0);
    push_exp(e0 + 2 * P + 8, S_FLT, 4'b0000, 1'b1);
    wait_until(e0 + 2 * P + 8 + 4);
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 3);
    pg_kill = 4'b0000;

    // runtime pg loss in ACTIVE
    power_up_full();
    pg_kill = 4'b1000;
    c = cyc;
    push_exp(c + 1 + SL, S_FLT, 4'b0000, 1'b1);
    @(posedge clk);
    #1 pg_kill = 4'b0000;
    wait_until(c + 1 + SL + 3);
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 3);

    // same pg loss in LB is ignored because rail 3 is off; then one-rail power-down goes straight to IDLE
    power_up_full();
    set_mode(1'b1, 1'b0, S_LB, 4'b0001);
    pg_kill = 4'b1000;
    @(posedge clk);
    #1 pg_kill = 4'b0000;
    wait_until(cyc + 4);
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 3);
    lb_sw = 1'b0;

    // abort during power-up with two rails on
    on_sw = 1'b1;
    e0 = cyc + 1 + SL;
    push_exp(e0, S_UP, 4'b0001, 1'b0);
    push_exp(e0 + P, S_UP, 4'b0011, 1'b0);
    wait_until(e0 + P + 1);
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_DN, 4'b0001, 1'b0);
    push_exp(d + 4, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 6);

    // lb_sw outranks lp_sw
    power_up_full();
    set_mode(1'b1, 1'b1, S_LB, 4'b0001);
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_IDLE, 4'b0000, 1'b0);
    wait_until(d + 3);
    lb_sw = 1'b0; lp_sw = 1'b0;

    // fault outranks a simultaneous on_sw drop
    power_up_full();
    pg_kill = 4'b1000;
    on_sw = 1'b0;
    c = cyc;
    push_exp(c + 1 + SL, S_FLT, 4'b0000, 1'b1);
    push_exp(c + 2 + SL, S_IDLE, 4'b0000, 1'b0);
    @(posedge clk);
    #1 pg_kill = 4'b0000;
    wait_until(c + 2 + SL + 3);

    // asynchronous reset in the middle of power-down
    power_up_full();
    on_sw = 1'b0;
    d = cyc + 1 + SL;
    push_exp(d, S_DN, 4'b0111, 1'b0);
    push_exp(d + 4, S_DN, 4'b0011, 1'b0);
    wait_until(d + 5);
    push_exp(cyc, S_IDLE, 4'b0000, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== S_IDLE || rail_en !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset got st=%0d re=%b, required st=0 re=0000", state, rail_en);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    wait_until(cyc + 5);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got %0d unconsumed, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
